sram_fifo_ctrl: RTL and testbench
=================================

Name: sram_fifo_ctrl

Overview:
- Synchronous FIFO controller that drives a single-port RW SRAM macro of 128x8 (one op per cycle, csb/web active low). It sits directly upstream of the macro and consumes the macro's read data.
- Producer side is a valid/ready push interface. Consumer side is a first-word-fall-through valid/ready pop interface.
- Storage lives in the macro. The block adds a 1-entry write staging register, a read pipeline tracker and a 3-entry output buffer.

Parameters:
- DATA_WIDTH, 8, word width; must match the macro.
- ADDR_WIDTH, 7, macro address width. DEPTH = 1<<ADDR_WIDTH (derived, 128).

Ports:
- clk0  in  1  clock; also drives the macro's clk0
- rst0_n  in  1  asynchronous active-low reset
- push_valid  in  1  producer has data
- push_ready  out  1  staging register empty
- push_data  in  DATA_WIDTH  write data
- pop_valid  out  1  output buffer head valid
- pop_ready  in  1  consumer accepts head
- pop_data  out  DATA_WIDTH  output buffer head
- count  out  ADDR_WIDTH+2  total entries held (staging + memory + in-flight + output buffer)
- sram_csb0  out  1  macro chip select, active low, registered
- sram_web0  out  1  macro write enable, active low, registered
- sram_addr0  out  ADDR_WIDTH  macro address, registered
- sram_din0  out  DATA_WIDTH  macro write data, registered
- sram_dout0  in  DATA_WIDTH  macro read data

Behaviour:
- Reset (async, rst0_n=0):
  - sram_csb0=1, sram_web0=1, sram_addr0=0, sram_din0=0.
  - push_ready=1, pop_valid=0, pop_data=0, count=0.
  - wr_ptr, rd_ptr, mem_count, in-flight bits and output buffer all cleared.
  - Memory contents are retained by the macro but treated as discarded.
  - A reset mid-operation abandons any in-flight read; its data is never captured.
- Push:
  - A push handshake (push_valid && push_ready) loads the staging register.
  - push_ready = !staging_full || write_granted_this_cycle.
- Macro command timing:
  - Command registers update on posedge E; the macro samples them at E+1.
  - Read data from sram_dout0 is captured into the output buffer at E+2.
  - Read latency is therefore 2 cycles. in_flight is a 2-stage valid shift.
  - Read data is captured only at the pipeline stage-2 edge; the value is undefined shortly after that edge.
- Eligibility (evaluated each cycle from registered state):
  - Write eligible: staging_full && mem_count < DEPTH.
  - Read eligible: mem_count > 0 && (obuf_count + inflight_count) < 3. A pop in the same cycle is not credited.
- Arbiter:
  - Only one command per cycle.
  - If only one op is eligible, grant it.
  - If both are eligible, alternate: grant the op not granted last time both contended. The first contention after reset grants the read.
  - If neither is eligible: csb0=1 and web0=1; addr/din hold their values.
- Write grant: csb0=0, web0=0, addr0=wr_ptr, din0=staging data; wr_ptr++, mem_count++, staging empties.
- Read grant: csb0=0, web0=1, addr0=rd_ptr; rd_ptr++, mem_count--, in_flight stage1 set.
- Pointer wrap: pointers are ADDR_WIDTH bits and wrap 127->0 naturally.
- Read-after-write safety: a read may be granted on the edge after the write grant to the same address. The macro completes the write before it samples that read. No hazard logic is required.
- Output buffer and pop:
  - The output buffer is a 3-entry FIFO. pop_valid = obuf_count>0; pop_data = head.
  - Capture and pop in the same cycle are both applied.
- Count: changes +1 on push, -1 on pop; both in the same cycle gives no change. Maximum value is DEPTH+4 = 132.
- Latency: push at edge T0 into an idle, empty FIFO gives pop_valid=1 after edge T4.
- Throughput: 1 macro op per cycle, shared between reads and writes.

Optional Feature:
- SRAM_FIFO_HWM_EN. When defined, the block adds:
  - Input hwm_clr (1 bit).
  - Output hwm (ADDR_WIDTH+2 bits): the maximum count since reset or the last hwm_clr.
  - hwm resets to 0.
  - On hwm_clr, hwm loads the current count the next cycle. hwm_clr has priority over the update.
- When undefined: no hwm ports and no hwm logic; all other behaviour is identical.

Test Plan:
- Single word: reset, push 0xA5 at T0, pop_ready=1.
  - Expect write cmd (csb0=0, web0=0, addr0=0, din0=0xA5) after T1 and read cmd (web0=1, addr0=0) after T2.
  - Expect pop_valid=1 with pop_data=0xA5 after T4; count goes 1 then 0 after the pop.
- Fill: push 0x00..0x83 (132 words) with pop_ready=0.
  - Expect count=132 and push_ready=0; the 133rd push stalls.
  - Then drain with pop_ready=1; expect 0x00..0x83 in order.
- Wrap: stream 300 incrementing words with push_valid=1 and pop_ready=1 throughout.
  - Expect in-order data and addr0 wrapping 127->0.
  - Expect reads and writes alternating under contention with no starvation.
- Pop backpressure: hold pop_ready=0 with 10 words queued.
  - Expect at most 3 reads issued (obuf full) and no further read until a pop occurs.
- Mid-operation reset: assert rst0_n=0 the cycle after a read grant.
  - Expect csb0=1, pop_valid=0, count=0 immediately, and no stale capture after release.
- HWM (SRAM_FIFO_HWM_EN defined): push 5 words then pop 5; expect hwm=5. Pulse hwm_clr; expect hwm=0.

Source files
------------

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: FIFO controller for a single-port 128x8 RW SRAM macro.
// The producer pushes through a one-entry staging register. The macro holds the bulk storage.
// Reads return after two cycles and land in a three-entry first-word-fall-through output buffer.
// The arbiter issues one macro command per cycle. When a read and a write contend, they alternate.
// Optional build macro SRAM_FIFO_HWM_EN adds a high-water-mark port pair (hwm, hwm_clr).
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
`ifdef SRAM_FIFO_HWM_EN
  ,
  input  logic                  hwm_clr,
  output logic [ADDR_WIDTH+1:0] hwm
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_M = (ADDR_WIDTH + 1)'(DEPTH);

  // Staging register
  logic                  staging_full_reg;
  logic [DATA_WIDTH-1:0] staging_data_reg;

  // Macro bookkeeping
  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [ADDR_WIDTH:0]   mem_count_reg;
  logic [1:0]            inflight_reg;    // [0] = command issued, [1] = data on dout next edge
  logic                  last_rd_reg;     // winner of the most recent read/write contention

  // Registered macro command
  logic                  csb_reg;
  logic                  web_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] din_reg;

  // Output buffer
  logic [2:0][DATA_WIDTH-1:0] obuf_q;
  logic [1:0]            obuf_head_reg;
  logic [1:0]            obuf_tail_reg;
  logic [1:0]            obuf_count_reg;

  logic [ADDR_WIDTH+1:0] count_reg;
  logic [ADDR_WIDTH+1:0] count_next;

  // Per-cycle decisions
  logic       wr_elig;
  logic       rd_elig;
  logic       grant_wr;
  logic       grant_rd;
  logic [1:0] inflight_count;
  logic       push_hs;
  logic       pop_hs;
  logic       capture;

  // Wrap a 0..2 output buffer index.
  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Eligibility and arbitration, computed from registered state only.
  always_comb begin
    inflight_count = 2'(inflight_reg[0]) + 2'(inflight_reg[1]);
    wr_elig  = staging_full_reg && (mem_count_reg < DEPTH_M);
    rd_elig  = (mem_count_reg != '0) &&
               ((3'(obuf_count_reg) + 3'(inflight_count)) < 3'd3);
    grant_wr = wr_elig && (!rd_elig || last_rd_reg);
    grant_rd = rd_elig && (!wr_elig || !last_rd_reg);
  end

  // Handshakes. The staging register accepts a new word in the same cycle its current word goes to the macro.
  always_comb begin
    push_ready = !staging_full_reg || grant_wr;
    pop_valid  = (obuf_count_reg != 2'd0);
    push_hs    = push_valid && push_ready;
    pop_hs     = pop_valid && pop_ready;
    capture    = inflight_reg[1];
  end

  // Head-of-buffer mux.
  always_comb begin
    case (obuf_head_reg)
      2'd1:    pop_data = obuf_q[1];
      2'd2:    pop_data = obuf_q[2];
      default: pop_data = obuf_q[0];
    endcase
  end

  // Net occupancy change: +1 per push, -1 per pop.
  always_comb begin
    case ({push_hs, pop_hs})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  assign count      = count_reg;
  assign sram_csb0  = csb_reg;
  assign sram_web0  = web_reg;
  assign sram_addr0 = addr_reg;
  assign sram_din0  = din_reg;

  // Staging register: fill on push, empty when its word is written to the macro.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      staging_full_reg <= 1'b0;
      staging_data_reg <= '0;
    end else if (push_hs) begin
      staging_full_reg <= 1'b1;
      staging_data_reg <= push_data;
    end else if (grant_wr) begin
      staging_full_reg <= 1'b0;
    end
  end

  // Macro command registers. When idle, address and data hold their values.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      csb_reg  <= 1'b1;
      web_reg  <= 1'b1;
      addr_reg <= '0;
      din_reg  <= '0;
    end else if (grant_wr) begin
      csb_reg  <= 1'b0;
      web_reg  <= 1'b0;
      addr_reg <= wr_ptr_reg;
      din_reg  <= staging_data_reg;
    end else if (grant_rd) begin
      csb_reg  <= 1'b0;
      web_reg  <= 1'b1;
      addr_reg <= rd_ptr_reg;
    end else begin
      csb_reg  <= 1'b1;
      web_reg  <= 1'b1;
    end
  end

  // Macro pointers and occupancy. The pointers wrap naturally at DEPTH.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      mem_count_reg <= '0;
    end else begin
      if (grant_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (grant_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (grant_wr)      mem_count_reg <= mem_count_reg + 1'b1;
      else if (grant_rd) mem_count_reg <= mem_count_reg - 1'b1;
    end
  end

  // Two-stage read tracker. Stage 2 marks the edge on which dout holds the read data.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) inflight_reg <= 2'b00;
    else         inflight_reg <= {inflight_reg[0], grant_rd};
  end

  // Remember the winner of a contention so that the other operation wins the next one.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n)                 last_rd_reg <= 1'b0;
    else if (wr_elig && rd_elig) last_rd_reg <= grant_rd;
  end

  // Output buffer storage: one register per entry, written only when it is the capture target.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_obuf
      logic [DATA_WIDTH-1:0] entry_reg;
      // Capture macro read data into this slot at pipeline stage 2.
      always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n)                                  entry_reg <= '0;
        else if (capture && (obuf_tail_reg == 2'(gi))) entry_reg <= sram_dout0;
      end
      assign obuf_q[gi] = entry_reg;
    end
  endgenerate

  // Output buffer pointers and occupancy. A capture and a pop in the same cycle both take effect.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      obuf_head_reg  <= 2'd0;
      obuf_tail_reg  <= 2'd0;
      obuf_count_reg <= 2'd0;
    end else begin
      if (capture) obuf_tail_reg <= inc3(obuf_tail_reg);
      if (pop_hs)  obuf_head_reg <= inc3(obuf_head_reg);
      case ({capture, pop_hs})
        2'b10:   obuf_count_reg <= obuf_count_reg + 2'd1;
        2'b01:   obuf_count_reg <= obuf_count_reg - 2'd1;
        default: obuf_count_reg <= obuf_count_reg;
      endcase
    end
  end

  // Total occupancy seen by the producer and consumer.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) count_reg <= '0;
    else         count_reg <= count_next;
  end

`ifdef SRAM_FIFO_HWM_EN
  logic [ADDR_WIDTH+1:0] hwm_reg;

  // High-water mark: a clear reloads the present count, otherwise track the running maximum.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n)                  hwm_reg <= '0;
    else if (hwm_clr)             hwm_reg <= count_reg;
    else if (count_next > hwm_reg) hwm_reg <= count_next;
  end

  assign hwm = hwm_reg;
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Testbench for sram_fifo_ctrl. It includes a behavioural 128x8 single-port macro.
// A queue model of the FIFO contents and occupancy checks the design.
module tb_sram_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 7;

  logic          clk0 = 1'b0;
  logic          rst0_n;
  logic          push_valid;
  logic          push_ready;
  logic [DW-1:0] push_data;
  logic          pop_valid;
  logic          pop_ready;
  logic [DW-1:0] pop_data;
  logic [AW+1:0] count;
  logic          sram_csb0;
  logic          sram_web0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout0;
`ifdef SRAM_FIFO_HWM_EN
  logic          hwm_clr;
  logic [AW+1:0] hwm;
`endif

  sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk0       (clk0),
    .rst0_n     (rst0_n),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_data),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_data   (pop_data),
    .count      (count),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0)
`ifdef SRAM_FIFO_HWM_EN
    ,
    .hwm_clr    (hwm_clr),
    .hwm        (hwm)
`endif
  );

  always #5 clk0 = ~clk0;

  // Macro model. It samples the command on the clock edge.
  // Read data appears shortly after that edge and is valid for one cycle only; at all other times dout carries garbage.
  logic [DW-1:0] mem [128];
  always @(posedge clk0) begin
    if (!sram_csb0 && !sram_web0) mem[sram_addr0] <= sram_din0;
    if (!sram_csb0 && sram_web0) sram_dout0 <= #1 mem[sram_addr0];
    else                          sram_dout0 <= #1 8'($urandom);
  end

  // Reference model state
  logic [DW-1:0] q[$];
  int n_cmp = 0;
  int n_err = 0;
  int rd_cmds, wr_cmds;
  int cyc;
  bit last_push;
  int hwm_model;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Apply reset with idle inputs, check the reset state, and clear the model.
  task automatic do_reset();
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    push_data  = '0;
`ifdef SRAM_FIFO_HWM_EN
    hwm_clr    = 1'b0;
`endif
    @(negedge clk0);
    rst0_n = 1'b0;
    #1;
    chk("rst_csb", sram_csb0, 1);
    chk("rst_web", sram_web0, 1);
    chk("rst_addr", sram_addr0, 0);
    chk("rst_din", sram_din0, 0);
    chk("rst_push_ready", push_ready, 1);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_pop_data", pop_data, 0);
    chk("rst_count", count, 0);
`ifdef SRAM_FIFO_HWM_EN
    chk("rst_hwm", hwm, 0);
`endif
    q.delete();
    rd_cmds = 0;
    wr_cmds = 0;
    hwm_model = 0;
    @(negedge clk0);
    @(negedge clk0);
    rst0_n = 1'b1;
  endtask

  // Advance one clock. The caller sets the inputs at the falling edge; this task applies the handshakes to the model.
  // After the edge it checks occupancy and the address of every issued macro command.
  task automatic cycle();
    bit ph, pp;
    int pre;
    #1;
    pre = q.size();
    ph = push_valid && push_ready;
    pp = pop_valid && pop_ready;
    if (pp) begin
      if (q.size() == 0) chk("pop_on_empty", pop_valid, 0);
      else begin
        chk("pop_data", pop_data, q[0]);
        void'(q.pop_front());
      end
    end
    if (ph) q.push_back(push_data);
    last_push = ph;
`ifdef SRAM_FIFO_HWM_EN
    if (hwm_clr) hwm_model = pre;
    else if (q.size() > hwm_model) hwm_model = q.size();
`endif
    @(posedge clk0);
    @(negedge clk0);
    cyc++;
    chk("count", count, q.size());
    if (!sram_csb0) begin
      if (!sram_web0) begin
        chk("wr_addr", sram_addr0, wr_cmds % 128);
        wr_cmds++;
      end else begin
        chk("rd_addr", sram_addr0, rd_cmds % 128);
        rd_cmds++;
      end
    end
`ifdef SRAM_FIFO_HWM_EN
    chk("hwm", hwm, hwm_model);
`endif
  endtask

  // Drain the FIFO with pop_ready held high, within a bounded number of cycles.
  task automatic drain(input string tag);
    int guard = 0;
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    while ((q.size() != 0 || pop_valid) && guard < 1000) begin
      cycle();
      guard++;
    end
    chk(tag, q.size(), 0);
    chk({tag, "_pop_valid"}, pop_valid, 0);
  endtask

  initial begin
    int v, guard, last_rd, last_wr, max_rd_gap, max_wr_gap, t0;
    bit found;
    rst0_n = 1'b1;
    cyc = 0;

    // Single word: check command and output timing against the push edge T0.
    do_reset();
    push_valid = 1'b1; push_data = 8'hA5; pop_ready = 1'b1;
    cycle();                                     // T0
    chk("sw_push_taken", 32'(last_push), 1);
    push_valid = 1'b0;
    cycle();                                     // T1
    chk("sw_wr_csb", sram_csb0, 0);
    chk("sw_wr_web", sram_web0, 0);
    chk("sw_wr_addr", sram_addr0, 0);
    chk("sw_wr_din", sram_din0, 8'hA5);
    cycle();                                     // T2
    chk("sw_rd_csb", sram_csb0, 0);
    chk("sw_rd_web", sram_web0, 1);
    chk("sw_rd_addr", sram_addr0, 0);
    cycle();                                     // T3
    chk("sw_not_yet_valid", pop_valid, 0);
    cycle();                                     // T4
    chk("sw_pop_valid", pop_valid, 1);
    chk("sw_pop_data", pop_data, 8'hA5);
    chk("sw_count_1", count, 1);
    cycle();                                     // pop
    chk("sw_count_0", count, 0);

    // Fill to 132 entries with the consumer stalled, then drain in order.
    do_reset();
    v = 0; guard = 0;
    while (v < 132 && guard < 1000) begin
      push_valid = 1'b1; push_data = 8'(v);
      cycle();
      if (last_push) v++;
      guard++;
    end
    chk("fill_accepted", v, 132);
    push_valid = 1'b1; push_data = 8'h84;
    for (int i = 0; i < 6; i++) cycle();
    #1;
    chk("fill_count", count, 132);
    chk("fill_push_ready", push_ready, 0);
    drain("fill_drain");

    // Stream 300 incrementing words with both sides always ready. The command addresses wrap.
    do_reset();
    v = 0; guard = 0; t0 = cyc;
    last_rd = -1; last_wr = -1; max_rd_gap = 0; max_wr_gap = 0;
    pop_ready = 1'b1;
    while (v < 300 && guard < 3000) begin
      push_valid = 1'b1; push_data = 8'(v);
      cycle();
      if (last_push) v++;
      if (!sram_csb0) begin
        if (sram_web0) begin
          if (last_rd >= 0 && cyc - last_rd > max_rd_gap) max_rd_gap = cyc - last_rd;
          last_rd = cyc;
        end else begin
          if (last_wr >= 0 && cyc - last_wr > max_wr_gap) max_wr_gap = cyc - last_wr;
          last_wr = cyc;
        end
      end
      guard++;
    end
    chk("stream_accepted", v, 300);
    chk("stream_throughput", 32'((cyc - t0) <= 700), 1);
    chk("stream_rd_gap", 32'(max_rd_gap <= 3), 1);
    chk("stream_wr_gap", 32'(max_wr_gap <= 3), 1);
    drain("stream_drain");
    chk("stream_wr_cmds", wr_cmds, 300);
    chk("stream_rd_cmds", rd_cmds, 300);

    // Pop backpressure: with 10 words queued, no more than 3 reads may be issued until a pop occurs.
    do_reset();
    v = 0; guard = 0;
    while (v < 10 && guard < 100) begin
      push_valid = 1'b1; push_data = 8'($urandom);
      cycle();
      if (last_push) v++;
      guard++;
    end
    push_valid = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    chk("bp_reads_3", rd_cmds, 3);
    chk("bp_pop_valid", pop_valid, 1);
    pop_ready = 1'b1;
    cycle();
    pop_ready = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    chk("bp_reads_4", rd_cmds, 4);
    drain("bp_drain");

    // Reset asserted the cycle after a read grant: the outstanding read is abandoned.
    do_reset();
    push_valid = 1'b1; push_data = 8'h3C;
    cycle();
    push_valid = 1'b0;
    found = 1'b0; guard = 0;
    while (!found && guard < 20) begin
      cycle();
      found = !sram_csb0 && sram_web0;
      guard++;
    end
    chk("mr_read_seen", 32'(found), 1);
    rst0_n = 1'b0;
    #1;
    chk("mr_csb", sram_csb0, 1);
    chk("mr_pop_valid", pop_valid, 0);
    chk("mr_count", count, 0);
    q.delete(); rd_cmds = 0; wr_cmds = 0; hwm_model = 0;
    @(negedge clk0);
    @(negedge clk0);
    rst0_n = 1'b1;
    pop_ready = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    chk("mr_no_stale", pop_valid, 0);

    // Random traffic: first a mostly-stalled consumer, then balanced traffic, then drain.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      push_valid = 1'($urandom_range(0, 3) != 0);
      push_data  = 8'($urandom);
      pop_ready  = 1'($urandom_range(0, 3) == 0);
      cycle();
    end
    for (int i = 0; i < 600; i++) begin
      push_valid = 1'($urandom_range(0, 1));
      push_data  = 8'($urandom);
      pop_ready  = 1'($urandom_range(0, 1));
      cycle();
    end
    drain("rand_drain");

`ifdef SRAM_FIFO_HWM_EN
    // High-water mark: push 5 words then pop 5, then clear.
    do_reset();
    v = 0; guard = 0;
    while (v < 5 && guard < 50) begin
      push_valid = 1'b1; push_data = 8'(v + 8'h40);
      cycle();
      if (last_push) v++;
      guard++;
    end
    push_valid = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    drain("hwm_drain");
    for (int i = 0; i < 2; i++) cycle();
    chk("hwm_peak", hwm, 5);
    hwm_clr = 1'b1;
    cycle();
    hwm_clr = 1'b0;
    cycle();
    chk("hwm_cleared", hwm, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog: stop if the stimulus stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
